// File: rtl/display_arbiter.sv
//------------------------------------------------------------------------------
// display_arbiter
//
// Shares one 4-digit 7-segment display driver between three requesters:
//   - calculator result (background, latched on a strobe),
//   - live keypad entry (shown while a level request is held),
//   - transient message (latched on a strobe, held for HOLD_CYCLES cycles).
// Priority is MSG > KEY > CALC > BLANK. The selected value and its
// leading-zero blanking count are registered toward the display driver.
// A free-running divider also produces the digit-scan clock for the driver.
//
// Parameters
//   SCAN_DIV     half-period of OUT_scan_clk in IN_clk cycles (>= 1)
//   HOLD_CYCLES  cycles a message stays on screen (>= 1)
//   BLANK_LZ     1: blank leading zero digits for calc/key sources, 0: show all
//
// Ports
//   IN_clk          in   1   system clock
//   IN_rst_n        in   1   asynchronous active-low reset
//   IN_calc_value   in   16  calculator result, 4 hex nibbles
//   IN_calc_valid   in   1   1-cycle strobe: capture IN_calc_value
//   IN_key_value    in   16  keypad entry in progress
//   IN_key_req      in   1   level: keypad entry active, show IN_key_value
//   IN_msg_value    in   16  transient message pattern
//   IN_msg_pulse    in   1   1-cycle strobe: capture IN_msg_value, start hold
//   OUT_value       out  16  display value, registered
//   OUT_off_number  out  3   blank top n digits (0 none .. 4 all), registered
//   OUT_scan_clk    out  1   digit-scan clock for the display
//   OUT_src         out  2   current source: 0 BLANK, 1 CALC, 2 KEY, 3 MSG
//------------------------------------------------------------------------------
module display_arbiter #(
    parameter int SCAN_DIV    = 25000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        IN_clk,
    input  logic        IN_rst_n,
    input  logic [15:0] IN_calc_value,
    input  logic        IN_calc_valid,
    input  logic [15:0] IN_key_value,
    input  logic        IN_key_req,
    input  logic [15:0] IN_msg_value,
    input  logic        IN_msg_pulse,
    output logic [15:0] OUT_value,
    output logic [2:0]  OUT_off_number,
    output logic        OUT_scan_clk,
    output logic [1:0]  OUT_src
);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_CALC  = 2'd1,
        ST_KEY   = 2'd2,
        ST_MSG   = 2'd3
    } state_t;

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // Blanking value for a fully blank display.
    localparam logic [2:0] OFF_ALL = 3'd4;

    state_t             state;
    logic [15:0]        calc_reg;
    logic               calc_seen;
    logic [15:0]        msg_reg;
    logic [HOLD_W-1:0]  hold;
    logic [SCAN_W-1:0]  scan_cnt;

    // Calculator view including a capture happening this very cycle, so a
    // strobe from BLANK/CALC is visible on the next clock.
    logic [15:0]        calc_next;
    logic               calc_seen_next;

    assign calc_next      = IN_calc_valid ? IN_calc_value : calc_reg;
    assign calc_seen_next = calc_seen | IN_calc_valid;

    assign OUT_src = state;

    //--------------------------------------------------------------------------
    // Leading-zero nibble count from the top digit, capped at 3 so a value of
    // zero still shows a single "0" on the lowest digit.
    //--------------------------------------------------------------------------
    function automatic logic [2:0] lz(input logic [15:0] v);
        logic [2:0] n;
        n = 3'd0;
        if (BLANK_LZ != 0) begin
            if (v[15:12] == 4'h0) begin
                n = 3'd1;
                if (v[11:8] == 4'h0) begin
                    n = 3'd2;
                    if (v[7:4] == 4'h0) begin
                        n = 3'd3;
                    end
                end
            end
        end
        return n;
    endfunction

    //--------------------------------------------------------------------------
    // Scan divider: free-running, toggles the scan clock on each wrap.
    //--------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            scan_cnt     <= '0;
            OUT_scan_clk <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt     <= '0;
            OUT_scan_clk <= ~OUT_scan_clk;
        end else begin
            scan_cnt     <= scan_cnt + SCAN_W'(1);
        end
    end

    //--------------------------------------------------------------------------
    // Calculator capture: accepted in every state, even while a message or
    // keypad entry hides it.
    //--------------------------------------------------------------------------
    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            calc_reg  <= '0;
            calc_seen <= 1'b0;
        end else if (IN_calc_valid) begin
            calc_reg  <= IN_calc_value;
            calc_seen <= 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Arbitration FSM with registered outputs. The branch order is the
    // priority order; outputs are loaded from the same decision as the state,
    // so they always describe the source the state register will hold.
    //--------------------------------------------------------------------------
    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            state          <= ST_BLANK;
            msg_reg        <= '0;
            hold           <= '0;
            OUT_value      <= '0;
            OUT_off_number <= OFF_ALL;
        end else if (IN_msg_pulse) begin
            // A new pulse relatches the message and restarts the timer, also
            // when a message is already on screen.
            state          <= ST_MSG;
            msg_reg        <= IN_msg_value;
            hold           <= HOLD_LOAD;
            OUT_value      <= IN_msg_value;
            OUT_off_number <= 3'd0;
        end else if (state == ST_MSG && hold != '0) begin
            state          <= ST_MSG;
            hold           <= hold - HOLD_W'(1);
            OUT_value      <= msg_reg;
            OUT_off_number <= 3'd0;
        end else if (IN_key_req) begin
            state          <= ST_KEY;
            hold           <= '0;
            OUT_value      <= IN_key_value;
            OUT_off_number <= lz(IN_key_value);
        end else if (calc_seen_next) begin
            state          <= ST_CALC;
            hold           <= '0;
            OUT_value      <= calc_next;
            OUT_off_number <= lz(calc_next);
        end else begin
            state          <= ST_BLANK;
            hold           <= '0;
            OUT_value      <= '0;
            OUT_off_number <= OFF_ALL;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
//------------------------------------------------------------------------------
// tb_display_arbiter
//
// Directed bench for display_arbiter with SCAN_DIV=2 and HOLD_CYCLES=5.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. after the edge that consumed the previous inputs.
//------------------------------------------------------------------------------
module tb_display_arbiter;

    localparam int SCAN_DIV    = 2;
    localparam int HOLD_CYCLES = 5;

    logic        clk;
    logic        rst_n;
    logic [15:0] calc_value;
    logic        calc_valid;
    logic [15:0] key_value;
    logic        key_req;
    logic [15:0] msg_value;
    logic        msg_pulse;
    logic [15:0] value;
    logic [2:0]  off_number;
    logic        scan_clk;
    logic [1:0]  src;

    int n_checks = 0;
    int n_fail   = 0;

    display_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLANK_LZ    (1)
    ) dut (
        .IN_clk         (clk),
        .IN_rst_n       (rst_n),
        .IN_calc_value  (calc_value),
        .IN_calc_valid  (calc_valid),
        .IN_key_value   (key_value),
        .IN_key_req     (key_req),
        .IN_msg_value   (msg_value),
        .IN_msg_pulse   (msg_pulse),
        .OUT_value      (value),
        .OUT_off_number (off_number),
        .OUT_scan_clk   (scan_clk),
        .OUT_src        (src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] e_src,
                              input logic [15:0] e_value, input logic [2:0] e_off);
        check({tag, ".src"},   32'(src),        32'(e_src));
        check({tag, ".value"}, 32'(value),      32'(e_value));
        check({tag, ".off"},   32'(off_number), 32'(e_off));
    endtask

    // Watchdog: the run is a fixed number of ticks, this only guards against
    // a stuck simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        calc_value = '0;
        calc_valid = 1'b0;
        key_value  = '0;
        key_req    = 1'b0;
        msg_value  = '0;
        msg_pulse  = 1'b0;

        // 1: reset values, then idle and scan clock toggling every 2 clocks.
        #12;
        expect_out("reset", 2'd0, 16'h0000, 3'd4);
        check("reset.scan", 32'(scan_clk), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("scan.e1", 32'(scan_clk), 32'd0);
        tick();
        check("scan.e2", 32'(scan_clk), 32'd1);
        tick();
        check("scan.e3", 32'(scan_clk), 32'd1);
        tick();
        check("scan.e4", 32'(scan_clk), 32'd0);
        expect_out("idle", 2'd0, 16'h0000, 3'd4);

        // 2: calculator captures and leading-zero blanking.
        calc_value = 16'h0042; calc_valid = 1'b1;
        tick();
        calc_valid = 1'b0;
        expect_out("calc42", 2'd1, 16'h0042, 3'd2);
        calc_value = 16'h0000; calc_valid = 1'b1;
        tick();
        calc_valid = 1'b0;
        expect_out("calc0", 2'd1, 16'h0000, 3'd3);
        calc_value = 16'h1000; calc_valid = 1'b1;
        tick();
        calc_valid = 1'b0;
        expect_out("calc1000", 2'd1, 16'h1000, 3'd0);
        tick();
        expect_out("calc_hold", 2'd1, 16'h1000, 3'd0);

        // 3: keypad entry overrides the calculator while requested.
        key_req = 1'b1; key_value = 16'h0007;
        tick();
        expect_out("key7", 2'd2, 16'h0007, 3'd3);
        key_value = 16'h0A07;
        tick();
        expect_out("keyA07", 2'd2, 16'h0A07, 3'd1);
        key_req = 1'b0;
        tick();
        expect_out("key_off", 2'd1, 16'h1000, 3'd0);

        // 4: message preempts keypad for exactly 5 cycles.
        key_req = 1'b1;
        tick();
        expect_out("key_again", 2'd2, 16'h0A07, 3'd1);
        msg_value = 16'h00AB; msg_pulse = 1'b1;
        tick();
        msg_pulse = 1'b0;
        expect_out("msg.c1", 2'd3, 16'h00AB, 3'd0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            expect_out($sformatf("msg.c%0d", i), 2'd3, 16'h00AB, 3'd0);
        end
        tick();
        expect_out("msg.exit", 2'd2, 16'h0A07, 3'd1);

        // 4b: re-pulse on the 4th message cycle relatches and restarts:
        // 8 message cycles in total.
        msg_value = 16'h00AB; msg_pulse = 1'b1;
        tick();
        msg_pulse = 1'b0;
        expect_out("rep.c1", 2'd3, 16'h00AB, 3'd0);
        tick();
        expect_out("rep.c2", 2'd3, 16'h00AB, 3'd0);
        tick();
        expect_out("rep.c3", 2'd3, 16'h00AB, 3'd0);
        msg_value = 16'h0CDE; msg_pulse = 1'b1;
        tick();
        msg_pulse = 1'b0;
        expect_out("rep.c4", 2'd3, 16'h0CDE, 3'd0);
        for (int i = 5; i <= 8; i++) begin
            tick();
            expect_out($sformatf("rep.c%0d", i), 2'd3, 16'h0CDE, 3'd0);
        end
        tick();
        expect_out("rep.exit", 2'd2, 16'h0A07, 3'd1);

        // 5: simultaneous calc capture and message; calc shows after hold.
        key_req    = 1'b0;
        calc_value = 16'h0123; calc_valid = 1'b1;
        msg_value  = 16'hBEEF; msg_pulse  = 1'b1;
        tick();
        calc_valid = 1'b0; msg_pulse = 1'b0;
        expect_out("both.c1", 2'd3, 16'hBEEF, 3'd0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            expect_out($sformatf("both.c%0d", i), 2'd3, 16'hBEEF, 3'd0);
        end
        tick();
        expect_out("both.exit", 2'd1, 16'h0123, 3'd1);

        // 6: asynchronous reset in the middle of a message.
        msg_value = 16'h5555; msg_pulse = 1'b1;
        tick();
        msg_pulse = 1'b0;
        expect_out("rst.pre", 2'd3, 16'h5555, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst.async", 2'd0, 16'h0000, 3'd4);
        check("rst.scan", 32'(scan_clk), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            expect_out($sformatf("rst.after%0d", i), 2'd0, 16'h0000, 3'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
